// File: rtl/riscv_muldiv_issue.sv
// Core-side issue/writeback sequencer for the sequential RISC-V M-extension unit.
// Optional define MULDIV_RESULT_CACHE_EN adds a one-entry result cache.
module riscv_muldiv_issue #(
  parameter int XLEN            = 32,
  parameter int WATCHDOG_CYCLES = 40
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            kill,
  output logic            md_enabled,
  output logic [2:0]      md_funct3,
  output logic [XLEN-1:0] md_s1,
  output logic [XLEN-1:0] md_s2,
  input  logic [XLEN-1:0] md_result,
  input  logic            md_wait,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err_timeout
);

  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;

  logic            div_by_zero;
  logic [WD_W-1:0] wdog_next;
  logic            wdog_expired;
  logic            cache_hit;
  logic [XLEN-1:0] cache_result;

  assign div_by_zero  = in_funct3[2] && (in_rs2 == '0);
  assign wdog_next    = wdog_q + 1'b1;
  assign wdog_expired = (wdog_next == WD_W'(WATCHDOG_CYCLES));

`ifdef MULDIV_RESULT_CACHE_EN
  logic            cache_valid_q, cache_valid_d;
  logic [2:0]      cache_f3_q, cache_f3_d;
  logic [XLEN-1:0] cache_rs1_q, cache_rs1_d;
  logic [XLEN-1:0] cache_rs2_q, cache_rs2_d;
  logic [XLEN-1:0] cache_res_q, cache_res_d;

  // Only results the unit really produced are remembered; kills and drains never fill.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_f3_d    = cache_f3_q;
    cache_rs1_d   = cache_rs1_q;
    cache_rs2_d   = cache_rs2_q;
    cache_res_d   = cache_res_q;
    if (state_q == RUN && !md_wait && !kill) begin
      cache_valid_d = 1'b1;
      cache_f3_d    = funct3_q;
      cache_rs1_d   = rs1_q;
      cache_rs2_d   = rs2_q;
      cache_res_d   = md_result;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
      cache_f3_q    <= '0;
      cache_rs1_q   <= '0;
      cache_rs2_q   <= '0;
      cache_res_q   <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_f3_q    <= cache_f3_d;
      cache_rs1_q   <= cache_rs1_d;
      cache_rs2_q   <= cache_rs2_d;
      cache_res_q   <= cache_res_d;
    end
  end

  assign cache_hit    = cache_valid_q && (in_funct3 == cache_f3_q) &&
                        (in_rs1 == cache_rs1_q) && (in_rs2 == cache_rs2_q);
  assign cache_result = cache_res_q;
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !kill) begin
          funct3_d = in_funct3;
          rs1_d    = in_rs1;
          rs2_d    = in_rs2;
          rd_d     = in_rd;
          if (div_by_zero) begin
            wb_data_d = in_funct3[1] ? in_rs1 : '1;
            state_d   = HOLD;
          end else if (cache_hit) begin
            wb_data_d = cache_result;
            state_d   = HOLD;
          end else begin
            wdog_d  = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        wdog_d = wdog_next;
        if (!md_wait) begin
          if (kill) begin
            state_d = IDLE;
          end else begin
            wb_data_d = md_result;
            state_d   = HOLD;
          end
        end else if (wdog_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (kill) begin
          // The unit cannot abort, so keep it enabled with the same operands until it finishes.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        wdog_d = wdog_next;
        if (!md_wait) begin
          state_d = IDLE;
        end else if (wdog_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (kill || wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      funct3_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign md_enabled  = (state_q == RUN) || (state_q == DRAIN);
  assign md_funct3   = funct3_q;
  assign md_s1       = rs1_q;
  assign md_s2       = rs2_q;
  assign wb_valid    = (state_q == HOLD);
  assign wb_rd       = rd_q;
  assign wb_data     = wb_data_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_riscv_muldiv_issue.sv
// Directed scoreboard bench for riscv_muldiv_issue with a behavioural sequential M-unit.
// Cache expectations follow MULDIV_RESULT_CACHE_EN when it is defined for the build.
module tb_riscv_muldiv_issue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic        kill = 1'b0;
  logic        md_enabled;
  logic [2:0]  md_funct3;
  logic [31:0] md_s1, md_s2, md_result;
  logic        md_wait;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_timeout;

  logic        stuck = 1'b0;
  int          unit_cnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_entry_t;
  sb_entry_t sb[$];

  riscv_muldiv_issue #(.XLEN(32), .WATCHDOG_CYCLES(40)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .kill(kill),
    .md_enabled(md_enabled), .md_funct3(md_funct3), .md_s1(md_s1), .md_s2(md_s2),
    .md_result(md_result), .md_wait(md_wait),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  // Arithmetic of the sequential unit for non-zero operands.
  function automatic logic [31:0] unit_calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y, p;
    logic [63:0]        u;
    logic signed [31:0] sa, sb2, q;
    sa  = a;
    sb2 = b;
    q   = '0;
    case (f)
      3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
      3'd1: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
      3'd2: begin x = {{32{a[31]}}, a}; y = {32'b0, b}; p = x * y; return p[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = sa / sb2; return q;
      end
      3'd5: return a / b;
      3'd6: begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = sa % sb2; return q;
      end
      default: return a % b;
    endcase
  endfunction

  // Unit model: zero operand finishes in the first cycle with 0, otherwise mul 6 / div 10 cycles.
  always @(posedge clock or posedge reset) begin
    if (reset) unit_cnt <= 0;
    else if (md_enabled) unit_cnt <= unit_cnt + 1;
    else unit_cnt <= 0;
  end

  logic unit_zero;
  int   unit_lat;
  assign unit_zero = (md_s1 == 32'h0) || (md_s2 == 32'h0);
  assign unit_lat  = md_funct3[2] ? 10 : 6;
  assign md_wait   = md_enabled && (stuck || (!unit_zero && unit_cnt != unit_lat - 1));
  assign md_result = unit_zero ? 32'h0 : unit_calc(md_funct3, md_s1, md_s2);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $display("[TB] FAIL %s wait bound expired observed=timeout expected=event", tag);
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input bit push, input logic [31:0] expv);
    int n = 0;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) timeoutFail("accept");
    in_valid  = 1'b1;
    in_funct3 = f;
    in_rs1    = a;
    in_rs2    = b;
    in_rd     = rd;
    if (push) sb.push_back('{rd, expv});
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic waitWb(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input bit exp_run, input int hold);
    int        n = 1;
    sb_entry_t e;
    while (!wb_valid && n < 100) begin
      if (exp_run) begin
        if (md_wait) begin
          checkOutput({tag, "_en"}, 32'(md_enabled), 32'd1);
          checkOutput({tag, "_s1"}, md_s1, a);
          checkOutput({tag, "_s2"}, md_s2, b);
          checkOutput({tag, "_f3"}, 32'(md_funct3), 32'(f));
        end
      end else begin
        checkOutput({tag, "_noen"}, 32'(md_enabled), 32'd0);
      end
      @(negedge clock);
      n++;
    end
    if (!wb_valid) begin
      timeoutFail({tag, "_wb"});
      return;
    end
    checkOutput({tag, "_lat"}, 32'(n), 32'(exp_lat));
    checkOutput({tag, "_en_hold"}, 32'(md_enabled), 32'd0);
    if (sb.size() == 0) begin
      timeoutFail({tag, "_sb_empty"});
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_data"}, wb_data, e.data);
    checkOutput({tag, "_rd"}, 32'(wb_rd), 32'(e.rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checkOutput({tag, "_hold_valid"}, 32'(wb_valid), 32'd1);
      checkOutput({tag, "_hold_data"}, wb_data, e.data);
      checkOutput({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    wb_ready = 1'b1;
    @(negedge clock);
    wb_ready = 1'b0;
    checkOutput({tag, "_done"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    int k;
    $display("[TB] start");
    repeat (2) @(negedge clock);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_md_en", 32'(md_enabled), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    reset = 1'b0;

    applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 1, 32'hFFFFFFEB);
    waitWb("mul_7x-3", 3'd0, 32'd7, 32'hFFFFFFFD, 7, 1, 0);

    applyStimulus(3'd0, 32'd0, 32'd5, 5'd2, 1, 32'd0);
    waitWb("mul_zero", 3'd0, 32'd0, 32'd5, 2, 1, 0);

    applyStimulus(3'd5, 32'd100, 32'd0, 5'd3, 1, 32'hFFFFFFFF);
    waitWb("divu_by0", 3'd5, 32'd100, 32'd0, 1, 0, 0);
    applyStimulus(3'd7, 32'd100, 32'd0, 5'd4, 1, 32'd100);
    waitWb("remu_by0", 3'd7, 32'd100, 32'd0, 1, 0, 0);

    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd5, 1, 32'h80000000);
    waitWb("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 11, 1, 0);
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd6, 1, 32'h0);
    waitWb("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 11, 1, 0);

    applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 1, 32'hFFFFFFFE);
    waitWb("mulhu_hold", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 1, 5);

    applyStimulus(3'd1, 32'hFFFFFFFE, 32'd3, 5'd8, 1, 32'hFFFFFFFF);
    waitWb("mulh_neg", 3'd1, 32'hFFFFFFFE, 32'd3, 7, 1, 0);
    applyStimulus(3'd4, 32'hFFFFFFEC, 32'd6, 5'd10, 1, 32'hFFFFFFFD);
    waitWb("div_neg", 3'd4, 32'hFFFFFFEC, 32'd6, 11, 1, 0);
    applyStimulus(3'd6, 32'hFFFFFFEC, 32'd6, 5'd11, 1, 32'hFFFFFFFE);
    waitWb("rem_neg", 3'd6, 32'hFFFFFFEC, 32'd6, 11, 1, 0);

    // Kill three cycles into a divide; the op must drain silently.
    applyStimulus(3'd4, 32'd1000, 32'd7, 5'd9, 0, 32'd0);
    repeat (2) @(negedge clock);
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin
      checkOutput("drain_no_wb", 32'(wb_valid), 32'd0);
      checkOutput("drain_en", 32'(md_enabled), 32'd1);
      checkOutput("drain_s1", md_s1, 32'd1000);
      @(negedge clock);
      k++;
    end
    if (!in_ready) timeoutFail("drain_exit");
    checkOutput("drain_idle_wb", 32'(wb_valid), 32'd0);
    checkOutput("drain_sb", 32'(sb.size()), 32'd0);
    applyStimulus(3'd5, 32'd9, 32'd3, 5'd12, 1, 32'd3);
    waitWb("divu_after_kill", 3'd5, 32'd9, 32'd3, 11, 1, 0);

    // Kill in the accept cycle drops the op.
    @(negedge clock);
    in_valid  = 1'b1;
    in_funct3 = 3'd0;
    in_rs1    = 32'd4;
    in_rs2    = 32'd4;
    kill      = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    kill     = 1'b0;
    checkOutput("idle_kill_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_kill_en", 32'(md_enabled), 32'd0);

    // Unit never finishes: watchdog fires at exactly 40 RUN cycles.
    stuck = 1'b1;
    applyStimulus(3'd0, 32'd2, 32'd3, 5'd13, 0, 32'd0);
    repeat (39) @(negedge clock);
    checkOutput("wd_before_err", 32'(err_timeout), 32'd0);
    checkOutput("wd_before_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    checkOutput("wd_err", 32'(err_timeout), 32'd1);
    checkOutput("wd_idle", 32'(in_ready), 32'd1);
    checkOutput("wd_no_wb", 32'(wb_valid), 32'd0);
    stuck = 1'b0;

    applyStimulus(3'd0, 32'd5, 32'd6, 5'd14, 1, 32'd30);
    waitWb("mul_5x6_first", 3'd0, 32'd5, 32'd6, 7, 1, 0);
    applyStimulus(3'd0, 32'd5, 32'd6, 5'd15, 1, 32'd30);
`ifdef MULDIV_RESULT_CACHE_EN
    waitWb("mul_5x6_repeat", 3'd0, 32'd5, 32'd6, 1, 0, 0);
`else
    waitWb("mul_5x6_repeat", 3'd0, 32'd5, 32'd6, 7, 1, 0);
`endif
    checkOutput("err_sticky", 32'(err_timeout), 32'd1);
    checkOutput("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
